uart_cmd_responder: RTL

//  Byte-level command engine on the parallel side of the UART peripheral. It consumes received

---
 rtl/uart_cmd_responder_pkg.sv | 34 +++
 rtl/uart_cmd_responder_if.sv | 36 +++
 rtl/uart_cmd_responder_byte_fetch.sv | 64 ++++++
 rtl/uart_cmd_responder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_responder_pkg.sv
// Shared definitions for the UART command responder.
//   - Command / response byte codes.
//   - Command FSM and byte-fetch FSM state encodings.
//   - Saturating 8-bit add used by the error counter.
package uart_cmd_responder_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_OK    = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR   = 8'h45;  // 'E'

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_GET_ADDR    = 3'd1,
    ST_GET_DATA    = 3'd2,
    ST_BUS_RD      = 3'd3,
    ST_TX_START    = 3'd4,
    ST_TX_WAIT_ON  = 3'd5,
    ST_TX_WAIT_OFF = 3'd6
  } state_e;

  typedef enum logic {
    FT_ARMED    = 1'b0,
    FT_WAIT_LOW = 1'b1
  } fetch_e;

  // Add 0..3 to an 8-bit count, clamping at 255.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] inc);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, inc};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/uart_cmd_responder_if.sv
// Host-side signal bundle of the UART command responder.
//   UART receive : rxData, dataReceived, dataOverrun, clearDR
//   UART transmit: txData, txRequest, txActive
//   Register bus : busAddr, busWrData, busWrite, busRead, busRdData
//   Status       : cmdErrors, busy
// master = the responder, slave = UART + register file side.
interface uart_cmd_responder_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]        rxData;
  logic              dataReceived;
  logic              dataOverrun;
  logic              clearDR;
  logic [7:0]        txData;
  logic              txRequest;
  logic              txActive;
  logic [ADDR_W-1:0] busAddr;
  logic [7:0]        busWrData;
  logic              busWrite;
  logic              busRead;
  logic [7:0]        busRdData;
  logic [7:0]        cmdErrors;
  logic              busy;

  modport master (
    input  rxData, dataReceived, dataOverrun, txActive, busRdData,
    output clearDR, txData, txRequest, busAddr, busWrData, busWrite, busRead,
           cmdErrors, busy
  );

  modport slave (
    output rxData, dataReceived, dataOverrun, txActive, busRdData,
    input  clearDR, txData, txRequest, busAddr, busWrData, busWrite, busRead,
           cmdErrors, busy
  );
endinterface

// File: rtl/uart_cmd_responder_byte_fetch.sv
// uart_byte_fetch: dataReceived/clearDR handshake toward the UART receiver.
//   clk, rst_n     : clock, async active-low reset
//   accept         : consumer can take a byte this cycle
//   data_received  : UART byte-ready level
//   rx_data        : UART byte
//   clear_dr       : one-cycle acknowledge to the UART
//   byte_valid     : one-cycle strobe, rx_byte valid
//   rx_byte        : captured byte
// After a capture the fetcher waits for data_received to drop before
// re-arming, so a level held high is captured exactly once.
module uart_byte_fetch
  import uart_cmd_responder_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       accept,
  input  logic       data_received,
  input  logic [7:0] rx_data,
  output logic       clear_dr,
  output logic       byte_valid,
  output logic [7:0] rx_byte
);

  fetch_e     st_q, st_d;
  logic       vld_q, vld_d;
  logic [7:0] byte_q, byte_d;

  always_comb begin
    st_d   = st_q;
    vld_d  = 1'b0;
    byte_d = byte_q;
    case (st_q)
      FT_ARMED: begin
        if (accept && data_received) begin
          byte_d = rx_data;
          vld_d  = 1'b1;
          st_d   = FT_WAIT_LOW;
        end
      end
      FT_WAIT_LOW: begin
        if (!data_received) st_d = FT_ARMED;
      end
      default: st_d = FT_ARMED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= FT_ARMED;
      vld_q  <= 1'b0;
      byte_q <= 8'h00;
    end else begin
      st_q   <= st_d;
      vld_q  <= vld_d;
      byte_q <= byte_d;
    end
  end

  // Acknowledge and strobe are the same registered pulse.
  assign clear_dr   = vld_q;
  assign byte_valid = vld_q;
  assign rx_byte    = byte_q;

endmodule

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: parses 'W' addr data / 'R' addr commands from UART
// bytes into single-cycle register-bus accesses and answers with one byte
// ('K' for write, read data for read, 'E' for an unknown command).
//   masterClock : clock, rising edge
//   reset       : asynchronous, active-low
//   io          : uart_cmd_responder_if.master (UART rx/tx, register bus,
//                 cmdErrors saturating error count, busy)
// Optional feature: define UART_CMD_TIMEOUT_EN to abort a partially received
// command after TIMEOUT_CYCLES idle cycles (counted as an error, no response).
module uart_cmd_responder
  import uart_cmd_responder_pkg::*;
#(
  parameter int ADDR_W = 4
`ifdef UART_CMD_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1000
`endif
) (
  input logic                  masterClock,
  input logic                  reset,
  uart_cmd_responder_if.master io
);

  state_e            state_q, state_d;
  logic              is_wr_q, is_wr_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [7:0]        bus_wr_data_q, bus_wr_data_d;
  logic              bus_write_q, bus_write_d;
  logic              bus_read_q, bus_read_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_request_q, tx_request_d;
  logic [7:0]        cmd_errors_q, cmd_errors_d;
  logic              ovr_q;

  logic       accept, byte_valid, clear_dr, ovr_edge, tmo_hit;
  logic [7:0] rx_byte;
  logic [1:0] err_inc;

  assign accept   = (state_q == ST_IDLE) || (state_q == ST_GET_ADDR) ||
                    (state_q == ST_GET_DATA);
  assign ovr_edge = io.dataOverrun && !ovr_q;

  uart_byte_fetch u_fetch (
    .clk           (masterClock),
    .rst_n         (reset),
    .accept        (accept),
    .data_received (io.dataReceived),
    .rx_data       (io.rxData),
    .clear_dr      (clear_dr),
    .byte_valid    (byte_valid),
    .rx_byte       (rx_byte)
  );

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             in_get;

  assign in_get = (state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA);
  // A byte arriving on the last allowed cycle wins over the timeout.
  assign tmo_hit = in_get && !byte_valid && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_d = '0;
    if (in_get && !byte_valid) tmo_d = tmo_q + TMO_W'(1);
  end

  always_ff @(posedge masterClock or negedge reset) begin
    if (!reset) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    is_wr_d       = is_wr_q;
    bus_addr_d    = bus_addr_q;
    bus_wr_data_d = bus_wr_data_q;
    bus_write_d   = 1'b0;
    bus_read_d    = 1'b0;
    tx_data_d     = tx_data_q;
    tx_request_d  = 1'b0;
    // Overrun edges count in every state; other sources add on top.
    err_inc       = {1'b0, ovr_edge};
    case (state_q)
      ST_IDLE: begin
        if (byte_valid) begin
          if (rx_byte == CMD_WRITE) begin
            is_wr_d = 1'b1;
            state_d = ST_GET_ADDR;
          end else if (rx_byte == CMD_READ) begin
            is_wr_d = 1'b0;
            state_d = ST_GET_ADDR;
          end else begin
            err_inc   = err_inc + 2'd1;
            tx_data_d = RSP_ERR;
            state_d   = ST_TX_START;
          end
        end
      end
      ST_GET_ADDR: begin
        if (ovr_edge || tmo_hit) begin
          if (tmo_hit) err_inc = err_inc + 2'd1;
          state_d = ST_IDLE;
        end else if (byte_valid) begin
          bus_addr_d = rx_byte[ADDR_W-1:0];
          if (is_wr_q) begin
            state_d = ST_GET_DATA;
          end else begin
            bus_read_d = 1'b1;
            state_d    = ST_BUS_RD;
          end
        end
      end
      ST_GET_DATA: begin
        if (ovr_edge || tmo_hit) begin
          if (tmo_hit) err_inc = err_inc + 2'd1;
          state_d = ST_IDLE;
        end else if (byte_valid) begin
          bus_wr_data_d = rx_byte;
          bus_write_d   = 1'b1;
          tx_data_d     = RSP_OK;
          state_d       = ST_TX_START;
        end
      end
      // Runs in the cycle busRead is high; the bus returns data one cycle
      // after the address was presented.
      ST_BUS_RD: begin
        tx_data_d = io.busRdData;
        state_d   = ST_TX_START;
      end
      ST_TX_START: begin
        tx_request_d = 1'b1;
        state_d      = ST_TX_WAIT_ON;
      end
      ST_TX_WAIT_ON: begin
        if (io.txActive) state_d = ST_TX_WAIT_OFF;
      end
      ST_TX_WAIT_OFF: begin
        if (!io.txActive) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    cmd_errors_d = sat_add8(cmd_errors_q, err_inc);
  end

  always_ff @(posedge masterClock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      is_wr_q       <= 1'b0;
      bus_addr_q    <= '0;
      bus_wr_data_q <= 8'h00;
      bus_write_q   <= 1'b0;
      bus_read_q    <= 1'b0;
      tx_data_q     <= 8'h00;
      tx_request_q  <= 1'b0;
      cmd_errors_q  <= 8'h00;
      ovr_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      is_wr_q       <= is_wr_d;
      bus_addr_q    <= bus_addr_d;
      bus_wr_data_q <= bus_wr_data_d;
      bus_write_q   <= bus_write_d;
      bus_read_q    <= bus_read_d;
      tx_data_q     <= tx_data_d;
      tx_request_q  <= tx_request_d;
      cmd_errors_q  <= cmd_errors_d;
      ovr_q         <= io.dataOverrun;
    end
  end

  assign io.clearDR   = clear_dr;
  assign io.busAddr   = bus_addr_q;
  assign io.busWrData = bus_wr_data_q;
  assign io.busWrite  = bus_write_q;
  assign io.busRead   = bus_read_q;
  assign io.txData    = tx_data_q;
  assign io.txRequest = tx_request_q;
  assign io.cmdErrors = cmd_errors_q;
  assign io.busy      = (state_q != ST_IDLE);

endmodule
